// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU execute unit with serial 1-bit/cycle shifter and valid/ready handshake
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [TAG_W-1:0]   out_tag
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, acc_sh, alu_res;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0] sh_op;
  logic is_shift, accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign is_shift  = alu_ctrl == 4'd5 || alu_ctrl == 4'd6 || alu_ctrl == 4'd7;
  always_comb begin
    state_nx = state == IDLE  ? (in_valid ? (is_shift ? SHIFT : DONE) : IDLE) :
               state == SHIFT ? (cnt == '0 ? DONE : SHIFT) :
               (out_ready ? IDLE : DONE);
  end
  // Unlisted codes (including 1010-1111) fall through to ADD like the decoder default.
  always_comb begin
    alu_res = alu_ctrl == 4'd1 ? op_a + ~op_b + 1'b1 :
              alu_ctrl == 4'd2 ? op_a ^ op_b :
              alu_ctrl == 4'd3 ? op_a | op_b :
              alu_ctrl == 4'd4 ? op_a & op_b :
              alu_ctrl == 4'd8 ? {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)} :
              alu_ctrl == 4'd9 ? {{(WIDTH-1){1'b0}}, op_a < op_b} :
              op_a + op_b;
  end
  always_comb begin
    acc_sh = sh_op == 2'b01 ? acc << 1 :
             sh_op == 2'b10 ? acc >> 1 :
             {acc[WIDTH-1], acc[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sh_op   <= '0;
      result  <= '0;
      zero    <= 1'b1;
      out_tag <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        out_tag <= in_tag;
        acc     <= op_a;
        cnt     <= op_b[SHAMT_W-1:0];
        sh_op   <= alu_ctrl[1:0];
        if (!is_shift) begin
          result <= alu_res;
          zero   <= alu_res == '0;
        end
      end
      if (state == SHIFT) begin
        if (cnt == '0) begin
          result <= acc;
          zero   <= acc == '0;
        end else begin
          acc <= acc_sh;
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule
